// File: rtl/s713_resp_misr.sv
// s713_resp_misr
// Output-response compactor for the s713 benchmark. Folds the 23 s713
// primary outputs into a 24-bit MISR over LEN qualified (VALID) cycles,
// leaving one signature per run.
//
// Parameters:
//   SEED   signature loaded on reset and at each run start
//   CNT_W  run-length counter width
// Ports:
//   CK      clock, rising edge
//   RST     synchronous active-high reset
//   START   run request, honoured in IDLE or DONE
//   LEN     VALID cycles to compact, sampled with an accepted START
//   VALID   D carries a valid s713 sample this cycle
//   D       s713 outputs (D[0]=G83 ... D[22]=G107)
//   BUSY    high while compacting
//   DONE    level, high once the run has finished
//   SIG     current signature
//   REMAIN  VALID cycles still to compact
// Optional feature (macro S713_RESP_MISR_GOLDEN_CMP_EN):
//   GOLDEN  expected signature
//   PASS    registered, final signature matched GOLDEN on entry to DONE
module s713_resp_misr #(
  parameter logic [23:0] SEED  = 24'h000000,
  parameter int          CNT_W = 16
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] LEN,
  input  logic             VALID,
  input  logic [22:0]      D,
`ifdef S713_RESP_MISR_GOLDEN_CMP_EN
  input  logic [23:0]      GOLDEN,
  output logic             PASS,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [23:0]      SIG,
  output logic [CNT_W-1:0] REMAIN
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [23:0]      sig_q, sig_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fb;
  logic [23:0]      sig_step;

  // Taps 24,23,22,17; D folds into bits 0..22, bit 23 only shifts in SIG[22].
  assign fb       = sig_q[23] ^ sig_q[22] ^ sig_q[21] ^ sig_q[16];
  assign sig_step = {sig_q[22:0], fb} ^ {1'b0, D};

`ifdef S713_RESP_MISR_GOLDEN_CMP_EN
  logic pass_q, pass_d;
`endif

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    remain_d = remain_q;
`ifdef S713_RESP_MISR_GOLDEN_CMP_EN
    pass_d   = pass_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          sig_d    = SEED;
          remain_d = LEN;
          state_d  = (LEN != '0) ? S_RUN : S_DONE;
`ifdef S713_RESP_MISR_GOLDEN_CMP_EN
          // A zero-length run enters DONE directly, so it is judged on SEED.
          pass_d   = (LEN == '0) ? (SEED == GOLDEN) : 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (VALID) begin
          sig_d    = sig_step;
          remain_d = remain_q - ONE;
          if (remain_q == ONE) begin
            state_d = S_DONE;
`ifdef S713_RESP_MISR_GOLDEN_CMP_EN
            pass_d  = (sig_step == GOLDEN);
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      sig_q    <= SEED;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef S713_RESP_MISR_GOLDEN_CMP_EN
      pass_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      remain_q <= remain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef S713_RESP_MISR_GOLDEN_CMP_EN
      pass_q   <= pass_d;
`endif
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign SIG    = sig_q;
  assign REMAIN = remain_q;
`ifdef S713_RESP_MISR_GOLDEN_CMP_EN
  assign PASS   = pass_q;
`endif

endmodule

// File: tb/tb_s713_resp_misr.sv
// Bench for s713_resp_misr: table of single-cycle vectors, a random run
// against a small MISR model, and optional golden-compare sequences.
module tb_s713_resp_misr;

  localparam int CNT_W = 16;

  logic             CK, RST, START, VALID;
  logic [CNT_W-1:0] LEN;
  logic [22:0]      D;
  logic             BUSY, DONE;
  logic [23:0]      SIG;
  logic [CNT_W-1:0] REMAIN;
`ifdef S713_RESP_MISR_GOLDEN_CMP_EN
  logic [23:0]      GOLDEN;
  logic             PASS;
`endif

  s713_resp_misr #(.SEED(24'h000000), .CNT_W(CNT_W)) dut (
    .CK(CK), .RST(RST), .START(START), .LEN(LEN), .VALID(VALID), .D(D),
`ifdef S713_RESP_MISR_GOLDEN_CMP_EN
    .GOLDEN(GOLDEN), .PASS(PASS),
`endif
    .BUSY(BUSY), .DONE(DONE), .SIG(SIG), .REMAIN(REMAIN)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    logic             rst, start, valid;
    logic [CNT_W-1:0] len;
    logic [22:0]      d;
    logic             busy, done;
    logic [23:0]      sig;
    logic [CNT_W-1:0] remain;
  } vec_t;

  typedef struct {
    logic             busy, done;
    logic [23:0]      sig;
    logic [CNT_W-1:0] remain;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic rst, logic start, logic [CNT_W-1:0] len,
                              logic valid, logic [22:0] d, logic busy,
                              logic done, logic [23:0] sig,
                              logic [CNT_W-1:0] remain);
    vec_t v;
    v.rst = rst; v.start = start; v.len = len; v.valid = valid; v.d = d;
    v.busy = busy; v.done = done; v.sig = sig; v.remain = remain;
    return v;
  endfunction

  function automatic logic [23:0] misr(logic [23:0] s, logic [22:0] d);
    logic f;
    f = s[23] ^ s[22] ^ s[21] ^ s[16];
    return {s[22:0], f} ^ {1'b0, d};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, queue its expected outcome, compare after the edge.
  task automatic step(string name, vec_t v);
    exp_t e;
    RST = v.rst; START = v.start; LEN = v.len; VALID = v.valid; D = v.d;
    e.busy = v.busy; e.done = v.done; e.sig = v.sig; e.remain = v.remain;
    sb.push_back(e);
    @(posedge CK); #1;
    e = sb.pop_front();
    chk({name, " busy"},   {31'd0, BUSY},  {31'd0, e.busy});
    chk({name, " done"},   {31'd0, DONE},  {31'd0, e.done});
    chk({name, " sig"},    {8'd0, SIG},    {8'd0, e.sig});
    chk({name, " remain"}, {16'd0, REMAIN}, {16'd0, e.remain});
  endtask

  initial begin
    logic [23:0]      m_sig;
    logic [CNT_W-1:0] m_rem;
    logic             v;
    logic [22:0]      d;
    RST = 1'b1; START = 1'b0; LEN = '0; VALID = 1'b0; D = '0;
`ifdef S713_RESP_MISR_GOLDEN_CMP_EN
    GOLDEN = 24'h000003;
`endif

    //          rst st  len       vl d          busy dn sig         rem
    tv.push_back(mk(1, 0, 16'd0,   0, 23'h0,     0, 0, 24'h000000, 16'd0));
    // LEN=4, D=0
    tv.push_back(mk(0, 1, 16'd4,   0, 23'h0,     1, 0, 24'h000000, 16'd4));
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h0,     1, 0, 24'h000000, 16'd3));
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h0,     1, 0, 24'h000000, 16'd2));
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h0,     1, 0, 24'h000000, 16'd1));
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h0,     0, 1, 24'h000000, 16'd0));
    // LEN=2, D=1 twice: 1 then (1<<1)^1 = 3
    tv.push_back(mk(0, 1, 16'd2,   0, 23'h0,     1, 0, 24'h000000, 16'd2));
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h1,     1, 0, 24'h000001, 16'd1));
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h1,     0, 1, 24'h000003, 16'd0));
    // LEN=2 with VALID 1,0,0,1
    tv.push_back(mk(0, 1, 16'd2,   0, 23'h0,     1, 0, 24'h000000, 16'd2));
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h1,     1, 0, 24'h000001, 16'd1));
    tv.push_back(mk(0, 0, 16'd0,   0, 23'h1,     1, 0, 24'h000001, 16'd1));
    tv.push_back(mk(0, 0, 16'd0,   0, 23'h1,     1, 0, 24'h000001, 16'd1));
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h1,     0, 1, 24'h000003, 16'd0));
    // VALID ignored in DONE
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h7fffff, 0, 1, 24'h000003, 16'd0));
    // LEN=0 goes straight to DONE with SEED
    tv.push_back(mk(0, 1, 16'd0,   1, 23'h5,     0, 1, 24'h000000, 16'd0));
    // LEN=10, three samples of 5: 5, 0xA^5=F, 0x1E^5=1B
    tv.push_back(mk(0, 1, 16'd10,  0, 23'h0,     1, 0, 24'h000000, 16'd10));
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h5,     1, 0, 24'h000005, 16'd9));
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h5,     1, 0, 24'h00000f, 16'd8));
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h5,     1, 0, 24'h00001b, 16'd7));
    // START in RUN ignored
    tv.push_back(mk(0, 1, 16'd3,   0, 23'h0,     1, 0, 24'h00001b, 16'd7));
    // mid-run reset
    tv.push_back(mk(1, 0, 16'd0,   1, 23'h5,     0, 0, 24'h000000, 16'd0));
    // max LEN is accepted as-is
    tv.push_back(mk(0, 1, 16'hffff, 0, 23'h0,    1, 0, 24'h000000, 16'hffff));
    tv.push_back(mk(0, 0, 16'd0,   1, 23'h2,     1, 0, 24'h000002, 16'hfffe));
    tv.push_back(mk(1, 0, 16'd0,   0, 23'h0,     0, 0, 24'h000000, 16'd0));

    foreach (tv[i]) step($sformatf("vec%0d", i), tv[i]);

    // Random run against the model, exercising feedback taps.
    m_sig = 24'h0; m_rem = 16'd40;
    step("rnd_start", mk(0, 1, 16'd40, 0, 23'h0, 1, 0, m_sig, m_rem));
    for (int i = 0; i < 400 && m_rem != 0; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 23'($urandom);
      if (v) begin
        m_sig = misr(m_sig, d);
        m_rem = m_rem - 16'd1;
      end
      step("rnd", mk(0, 0, 16'd0, v, d, m_rem != 0, m_rem == 0, m_sig, m_rem));
    end
    chk("rnd_finished", {31'd0, DONE}, 32'd1);

`ifdef S713_RESP_MISR_GOLDEN_CMP_EN
    GOLDEN = 24'h000003;
    step("g1s", mk(0, 1, 16'd2, 0, 23'h0, 1, 0, 24'h0, 16'd2));
    chk("pass_start_clear", {31'd0, PASS}, 32'd0);
    step("g1a", mk(0, 0, 16'd0, 1, 23'h1, 1, 0, 24'h1, 16'd1));
    step("g1b", mk(0, 0, 16'd0, 1, 23'h1, 0, 1, 24'h3, 16'd0));
    chk("pass_match", {31'd0, PASS}, 32'd1);
    step("g1h", mk(0, 0, 16'd0, 0, 23'h0, 0, 1, 24'h3, 16'd0));
    chk("pass_hold", {31'd0, PASS}, 32'd1);
    GOLDEN = 24'h000004;
    step("g2s", mk(0, 1, 16'd2, 0, 23'h0, 1, 0, 24'h0, 16'd2));
    chk("pass_restart_clear", {31'd0, PASS}, 32'd0);
    step("g2a", mk(0, 0, 16'd0, 1, 23'h1, 1, 0, 24'h1, 16'd1));
    step("g2b", mk(0, 0, 16'd0, 1, 23'h1, 0, 1, 24'h3, 16'd0));
    chk("pass_mismatch", {31'd0, PASS}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
